// File: rtl/pu_ram_arbiter.sv
// Round-robin arbiter that lets PU_COUNT processing units share one single-port RAM.
// Issues one registered command per cycle and routes read data back to the issuing PU.
module pu_ram_arbiter #(
  parameter int RAM_WIDTH  = 16,
  parameter int PU_COUNT   = 7,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PU_COUNT-1:0]            req,
  input  logic [PU_COUNT-1:0]            wr_n_rd,
  input  logic [PU_COUNT*RAM_WIDTH-1:0]  wr_data,
  input  logic [PU_COUNT*ADDR_WIDTH-1:0] addr,
  output logic [PU_COUNT-1:0]            ack,
  output logic                           ram_en,
  output logic                           ram_we,
  output logic [ADDR_WIDTH-1:0]          ram_addr,
  output logic [RAM_WIDTH-1:0]           ram_wdata,
  input  logic [RAM_WIDTH-1:0]           ram_rdata,
  output logic [PU_COUNT-1:0]            rd_valid,
  output logic [RAM_WIDTH-1:0]           rd_data
);

  localparam int                  ID_W     = $clog2(PU_COUNT);
  localparam logic [ID_W:0]       PU_CNT   = (ID_W+1)'(PU_COUNT);
  localparam logic [ID_W-1:0]     LAST_ID  = ID_W'(PU_COUNT - 1);
  localparam logic [PU_COUNT-1:0] ONE_HOT0 = PU_COUNT'(1);

  logic [ADDR_WIDTH-1:0] addr_arr  [PU_COUNT];
  logic [RAM_WIDTH-1:0]  wdata_arr [PU_COUNT];

  for (genvar i = 0; i < PU_COUNT; i++) begin : g_unpack
    assign addr_arr[i]  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[i] = wr_data[i*RAM_WIDTH +: RAM_WIDTH];
  end

  logic [ID_W-1:0]     ptr;
  logic [PU_COUNT-1:0] eligible;
  logic                grant_found;
  logic [ID_W-1:0]     grant_id;
  logic [ID_W:0]       cand;

  // Read-command id pipeline: s1 aligns with the RAM command, s2 with ram_rdata.
  logic            s1_valid, s2_valid;
  logic [ID_W-1:0] s1_id, s2_id;

  // A PU acked this cycle is still showing its old request, so it is masked out.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    eligible    = req & ~ack;
    grant_found = 1'b0;
    grant_id    = ptr;
    cand        = '0;
    for (int k = 0; k < PU_COUNT; k++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(k);
      if (cand >= PU_CNT) cand = cand - PU_CNT;
      if (!grant_found && eligible[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = cand[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
    if (rst) begin
      ptr       <= '0;
      ack       <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      s1_valid  <= 1'b0;
      s1_id     <= '0;
      s2_valid  <= 1'b0;
      s2_id     <= '0;
      rd_valid  <= '0;
      rd_data   <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      rd_valid <= s2_valid ? (ONE_HOT0 << s2_id) : '0;
      if (s2_valid) rd_data <= ram_rdata;

      if (grant_found) begin
        ptr       <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
        ack       <= ONE_HOT0 << grant_id;
        ram_en    <= 1'b1;
        ram_we    <= wr_n_rd[grant_id];
        ram_addr  <= addr_arr[grant_id];
        ram_wdata <= wdata_arr[grant_id];
        s1_valid  <= ~wr_n_rd[grant_id];
        s1_id     <= grant_id;
      end else begin
        // Address and write data deliberately hold when idle.
        ack      <= '0;
        ram_en   <= 1'b0;
        ram_we   <= 1'b0;
        s1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pu_ram_arbiter.sv
// Self-checking bench for pu_ram_arbiter: directed literal cases plus randomized
// traffic compared every cycle against a queue-based behavioural model and a RAM model.
module tb_pu_ram_arbiter;

  localparam int N = 7;
  localparam int W = 16;
  localparam int A = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   wr_n_rd = '0;
  logic [N*W-1:0] wr_data = '0;
  logic [N*A-1:0] addr = '0;
  logic [N-1:0]   ack;
  logic           ram_en;
  logic           ram_we;
  logic [A-1:0]   ram_addr;
  logic [W-1:0]   ram_wdata;
  logic [W-1:0]   ram_rdata = '0;
  logic [N-1:0]   rd_valid;
  logic [W-1:0]   rd_data;

  pu_ram_arbiter #(.RAM_WIDTH(W), .PU_COUNT(N), .ADDR_WIDTH(A)) dut (
    .clk(clk), .rst(rst), .req(req), .wr_n_rd(wr_n_rd), .wr_data(wr_data),
    .addr(addr), .ack(ack), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .rd_valid(rd_valid), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RAM model: one-cycle read latency, write on the command edge.
  logic [W-1:0] ram_mem   [256];
  logic [W-1:0] model_mem [256];

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] = ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  // Behavioural model: expected outputs for the next cycle, pending reads with due cycles.
  typedef struct {
    int           due;
    int           pu;
    logic [W-1:0] data;
  } rd_t;

  rd_t          pend[$];
  logic [N-1:0] exp_ack, exp_rd_valid;
  logic         exp_en, exp_we;
  logic [A-1:0] exp_addr;
  logic [W-1:0] exp_wdata, exp_rd_data;
  int           ptr = 0;
  int           cyc = 0;
  bit           model_valid = 1'b0;

  always @(negedge clk) begin
    logic [N-1:0] elig;
    int           g;
    bit           found;
    if (model_valid) begin
      check("m_ack",       64'(ack),       64'(exp_ack));
      check("m_ram_en",    64'(ram_en),    64'(exp_en));
      check("m_ram_we",    64'(ram_we),    64'(exp_we));
      check("m_ram_addr",  64'(ram_addr),  64'(exp_addr));
      check("m_ram_wdata", 64'(ram_wdata), 64'(exp_wdata));
      check("m_rd_valid",  64'(rd_valid),  64'(exp_rd_valid));
      check("m_rd_data",   64'(rd_data),   64'(exp_rd_data));
    end
    if (rst) begin
      exp_ack = '0; exp_en = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
      exp_rd_valid = '0; exp_rd_data = '0;
      ptr = 0;
      pend.delete();
      model_valid = 1'b1;
    end else if (model_valid) begin
      exp_rd_valid = '0;
      if (pend.size() > 0 && pend[0].due == cyc + 1) begin
        exp_rd_valid = N'(1) << pend[0].pu;
        exp_rd_data  = pend[0].data;
        void'(pend.pop_front());
      end
      elig  = req & ~exp_ack;
      found = 1'b0;
      g     = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && elig[(ptr + k) % N]) begin
          found = 1'b1;
          g     = (ptr + k) % N;
        end
      end
      if (found) begin
        exp_ack   = N'(1) << g;
        exp_en    = 1'b1;
        exp_we    = wr_n_rd[g];
        exp_addr  = addr[g*A +: A];
        exp_wdata = wr_data[g*W +: W];
        ptr       = (g + 1) % N;
        if (exp_we) model_mem[exp_addr] = exp_wdata;
        else        pend.push_back('{due: cyc + 3, pu: g, data: model_mem[exp_addr]});
      end else begin
        exp_ack = '0;
        exp_en  = 1'b0;
        exp_we  = 1'b0;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pu(input int i, input bit wr, input logic [A-1:0] a, input logic [W-1:0] d);
    req[i]          = 1'b1;
    wr_n_rd[i]      = wr;
    addr[i*A +: A]  = a;
    wr_data[i*W +: W] = d;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_mem[i]   = W'(i * 257) ^ 16'h5a5a;
      model_mem[i] = ram_mem[i];
    end
    ram_mem[8'h40]   = 16'h1234;
    model_mem[8'h40] = 16'h1234;

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state, then single write from PU 3.
    set_pu(3, 1'b1, 8'h12, 16'hBEEF);
    @(negedge clk);
    check("rst_ack",      64'(ack),       64'(0));
    check("rst_ram_en",   64'(ram_en),    64'(0));
    check("rst_ram_addr", 64'(ram_addr),  64'(0));
    check("rst_rd_valid", 64'(rd_valid),  64'(0));
    check("rst_rd_data",  64'(rd_data),   64'(0));
    tick();
    req = '0;
    @(negedge clk);
    check("wr_ack",       64'(ack),       64'(7'h08));
    check("wr_ram_en",    64'(ram_en),    64'(1));
    check("wr_ram_we",    64'(ram_we),    64'(1));
    check("wr_ram_addr",  64'(ram_addr),  64'(8'h12));
    check("wr_ram_wdata", 64'(ram_wdata), 64'(16'hBEEF));
    check("wr_rd_valid",  64'(rd_valid),  64'(0));

    // Read from PU 5, data returns three cycles after the grant decision.
    tick();
    set_pu(5, 1'b0, 8'h40, 16'h0);
    tick();
    req = '0;
    @(negedge clk);
    check("rd_ack",      64'(ack),      64'(7'h20));
    check("rd_ram_we",   64'(ram_we),   64'(0));
    check("rd_ram_addr", 64'(ram_addr), 64'(8'h40));
    tick();
    @(negedge clk);
    check("rd_early_valid", 64'(rd_valid), 64'(0));
    tick();
    @(negedge clk);
    check("rd_valid", 64'(rd_valid), 64'(7'h20));
    check("rd_data",  64'(rd_data),  64'(16'h1234));

    // Wrap-around: after PU 6, PU 0 beats PU 5.
    tick();
    set_pu(6, 1'b1, 8'h77, 16'h6666);
    tick();
    req[6] = 1'b0;
    set_pu(0, 1'b1, 8'h01, 16'h0A0A);
    set_pu(5, 1'b1, 8'h05, 16'h5050);
    @(negedge clk);
    check("wrap_ack6", 64'(ack), 64'(7'h40));
    tick();
    req[0] = 1'b0;
    @(negedge clk);
    check("wrap_ack0", 64'(ack), 64'(7'h01));
    tick();
    req[5] = 1'b0;
    @(negedge clk);
    check("wrap_ack5", 64'(ack), 64'(7'h20));

    // Lone requester: granted every other cycle.
    tick();
    set_pu(2, 1'b1, 8'h02, 16'h2222);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 7) req[2] = 1'b0;
      @(negedge clk);
      check("solo_en",  64'(ram_en), 64'(k % 2));
      check("solo_ack", 64'(ack),    64'((k % 2 == 1) ? 7'h04 : 7'h00));
    end

    // All PUs requesting after reset: strict rotation from PU 0, a command every cycle.
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_pu(i, 1'b1, A'(8'h30 + i), W'(16'h1000 + i));
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 14) req = '0;
      @(negedge clk);
      check("rr_ack", 64'(ack),    64'(N'(1) << ((k - 1) % N)));
      check("rr_en",  64'(ram_en), 64'(1));
    end

    // Reads in flight are discarded by reset.
    tick();
    set_pu(1, 1'b0, 8'h12, 16'h0);
    tick();
    req[1] = 1'b0;
    set_pu(4, 1'b0, 8'h40, 16'h0);
    @(negedge clk);
    check("flush_ack1", 64'(ack), 64'(7'h02));
    tick();
    req[4] = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    check("flush_ack4", 64'(ack), 64'(7'h10));
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("flush_ack",      64'(ack),       64'(0));
    check("flush_ram_en",   64'(ram_en),    64'(0));
    check("flush_ram_we",   64'(ram_we),    64'(0));
    check("flush_ram_addr", 64'(ram_addr),  64'(0));
    check("flush_wdata",    64'(ram_wdata), 64'(0));
    check("flush_rd_valid", 64'(rd_valid),  64'(0));
    check("flush_rd_data",  64'(rd_data),   64'(0));
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      check("flush_no_valid", 64'(rd_valid), 64'(0));
    end

    // Randomized traffic; PUs hold fields until acked and occasionally withdraw.
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < N; i++) begin
        if (exp_ack[i] || !req[i]) begin
          if ($urandom_range(0, 1) == 1)
            set_pu(i, 1'($urandom_range(0, 1)), A'($urandom_range(0, 15)), W'($urandom));
          else
            req[i] = 1'b0;
        end else if ($urandom_range(0, 31) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    tick();
    req = '0;
    rst = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pu_ram_arbiter.md
PU_RAM_ARBITER -- requirements
Module: pu_ram_arbiter

Interface
REQ-001 Parameter RAM_WIDTH, default 16, data width per processing unit (PU) in bits.
REQ-002 Parameter PU_COUNT, default 7, number of PU request ports; legal range 2..16.
REQ-003 Parameter ADDR_WIDTH, default 8, RAM address width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  PU_COUNT  per-PU access request, bit i = PU i.
REQ-007 wr_n_rd  input  PU_COUNT  per-PU direction, 1 = write, 0 = read.
REQ-008 wr_data  input  PU_COUNT*RAM_WIDTH  packed write data, PU i in bits [i*RAM_WIDTH +: RAM_WIDTH].
REQ-009 addr  input  PU_COUNT*ADDR_WIDTH  packed address, PU i in bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 ack  output  PU_COUNT  one-cycle, one-hot pulse: request of PU i accepted.
REQ-011 ram_en  output  1  RAM access strobe.
REQ-012 ram_we  output  1  RAM write enable, qualified by ram_en.
REQ-013 ram_addr  output  ADDR_WIDTH  RAM address.
REQ-014 ram_wdata  output  RAM_WIDTH  RAM write data.
REQ-015 ram_rdata  input  RAM_WIDTH  RAM read data, valid exactly 1 cycle after a read command.
REQ-016 rd_valid  output  PU_COUNT  one-hot, one-cycle pulse: rd_data belongs to PU i.
REQ-017 rd_data  output  RAM_WIDTH  returned read data.

Function
REQ-018 Eligible set in cycle N = req & ~ack (a PU acknowledged in cycle N is excluded in N, which prevents double issue).
REQ-019 Round-robin selection: search starts at pointer P and wraps modulo PU_COUNT; first eligible PU wins.
REQ-020 On a grant to PU g, P becomes (g+1) mod PU_COUNT at the next edge; without a grant, P holds.
REQ-021 Grant decided in cycle N; ack[g], ram_en=1, ram_we=wr_n_rd[g], ram_addr=addr[g], ram_wdata=wr_data[g] are all registered and appear in cycle N+1 for exactly one cycle.
REQ-022 No grant in cycle N: in cycle N+1, ram_en=0, ram_we=0, ack=0; ram_addr/ram_wdata hold their previous values.
REQ-023 A PU holds req, wr_n_rd, addr and wr_data stable from req assertion until the cycle ack[i] is high; it may change them, or deassert req, in that ack cycle.
REQ-024 Read path: a read command in cycle N+1 is answered by ram_rdata in N+2, which is registered into rd_data with rd_valid[g]=1 in N+3.
REQ-025 The PU id is pipelined through two stages alongside the command; back-to-back reads to different PUs return in issue order, one per cycle.
REQ-026 Writes never produce rd_valid.
REQ-027 rd_data holds its value when rd_valid=0.
REQ-028 Throughput: one RAM command per cycle while two or more PUs request; a single PU requesting continuously is granted every other cycle.
REQ-029 Fairness: a continuously requesting PU is granted within PU_COUNT grants.
REQ-030 Request deasserted before its grant: no command is issued for it; no error is reported.

Reset
REQ-031 While rst=1 at an edge: P=0, ack=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, rd_valid=0, rd_data=0, both id pipeline stages invalid.
REQ-032 Reset mid-operation discards in-flight reads; no rd_valid pulse follows reset deassertion for commands issued before reset.
REQ-033 First cycle after reset: PU 0 has highest priority.

Verification
REQ-034 Single write: PU 3 req, wr_n_rd=1, addr=0x12, data=0xBEEF in cycle 0 -> cycle 1: ack=0x08, ram_en=1, ram_we=1, ram_addr=0x12, ram_wdata=0xBEEF; no rd_valid.
REQ-035 Read return: PU 5 reads addr 0x40 in cycle 0, RAM model returns 0x1234 -> cycle 3: rd_valid=0x20, rd_data=0x1234.
REQ-036 All 7 PUs request continuously after reset -> grant order 0,1,2,3,4,5,6,0,...; ram_en high every cycle.
REQ-037 Only PU 2 requests continuously -> ack[2] pulses in alternating cycles; ram_en duty 50%.
REQ-038 Reads from PU 1 and PU 4 issued in consecutive cycles, then rst asserted in the cycle after the second issue -> no rd_valid ever; all outputs 0 the cycle after the reset edge.
REQ-039 After granting PU 6, requests from PU 0 and PU 5 arrive together -> PU 0 granted first (wrap-around), then PU 5.
